// File: rtl/csr_access_sequencer.sv
// CSR access sequencer: arbitrates the commit-side CSR port and the debug
// abstract-command port onto the single CSR file port, one access at a time,
// with a response timeout and flush-based kill of core accesses.
package csr_access_sequencer_pkg;
  typedef enum logic [2:0] {
    CSR_CMD_NONE  = 3'd0,
    CSR_CMD_READ  = 3'd1,
    CSR_CMD_WRITE = 3'd2,
    CSR_CMD_SET   = 3'd3,
    CSR_CMD_CLEAR = 3'd4,
    CSR_CMD_RW    = 3'd5,
    CSR_CMD_SYS   = 3'd6
  } csr_cmd_t;
endpackage

module csr_access_sequencer
  import csr_access_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        core_req_valid_i,
  output logic        core_req_ready_o,
  input  csr_cmd_t    core_req_cmd_i,
  input  logic [11:0] core_req_addr_i,
  input  logic [63:0] core_req_data_i,
  output logic        core_resp_valid_o,
  output logic [63:0] core_resp_data_o,
  output logic        core_resp_xcpt_o,
  input  logic        flush_i,
  input  logic        dbg_req_valid_i,
  output logic        dbg_req_ready_o,
  input  logic        dbg_req_write_i,
  input  logic [11:0] dbg_req_addr_i,
  input  logic [63:0] dbg_req_data_i,
  output logic        dbg_resp_valid_o,
  output logic [63:0] dbg_resp_data_o,
  output logic        dbg_resp_err_o,
  input  logic        debug_mode_i,
  output logic        csr_req_valid_o,
  output csr_cmd_t    csr_req_cmd_o,
  output logic [11:0] csr_req_addr_o,
  output logic [63:0] csr_req_data_o,
  input  logic        csr_resp_valid_i,
  input  logic [63:0] csr_resp_data_i,
  input  logic        csr_resp_xcpt_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic {OWN_CORE, OWN_DBG} owner_t;

  // Last timer value allowed in WAIT before the access is declared dead.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  owner_t      rr_last_q, rr_last_d;
  logic [7:0]  timer_q, timer_d;
  logic        kill_q, kill_d;
  csr_cmd_t    cmd_q, cmd_d;
  logic [11:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic core_ok, dbg_ok, tie;
  logic core_rdy, dbg_rdy, csr_vld;

  assign core_ok = core_req_valid_i & ~flush_i;
  assign dbg_ok  = dbg_req_valid_i & debug_mode_i;
  assign tie     = core_ok & dbg_ok;

  // Control state: reset to IDLE with the core favoured on the first tie.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_CORE;
      rr_last_q <= OWN_DBG;
      timer_q   <= '0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      timer_q   <= timer_d;
      kill_q    <= kill_d;
    end
  end

  // Access payload and response capture; outputs are gated so no reset is needed.
  always_ff @(posedge clk_i) begin
    cmd_q   <= cmd_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
    err_q   <= err_d;
  end

  // Next-state, grant, issue, timeout and kill decisions.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    timer_d   = timer_q;
    kill_d    = kill_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    core_rdy  = 1'b0;
    dbg_rdy   = 1'b0;
    csr_vld   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // On a tie only the side that did not win last time sees ready.
        if (rstn_i) begin
          core_rdy = ~flush_i & ~(tie & (rr_last_q == OWN_CORE));
          dbg_rdy  = debug_mode_i & ~(tie & (rr_last_q == OWN_DBG));
        end
        if (core_req_valid_i && core_rdy) begin
          owner_d   = OWN_CORE;
          rr_last_d = OWN_CORE;
          cmd_d     = core_req_cmd_i;
          addr_d    = core_req_addr_i;
          wdata_d   = core_req_data_i;
          state_d   = S_ISSUE;
        end else if (dbg_req_valid_i && dbg_rdy) begin
          owner_d   = OWN_DBG;
          rr_last_d = OWN_DBG;
          cmd_d     = dbg_req_write_i ? CSR_CMD_WRITE : CSR_CMD_READ;
          addr_d    = dbg_req_addr_i;
          wdata_d   = dbg_req_data_i;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        kill_d  = 1'b0;
        // A flushed core access is dropped before it reaches the CSR file.
        if (owner_q == OWN_CORE && flush_i) begin
          state_d = S_IDLE;
        end else begin
          csr_vld = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The side effect is already committed, so a flush only mutes the reply.
        if (owner_q == OWN_CORE && flush_i) kill_d = 1'b1;
        if (csr_resp_valid_i) begin
          rdata_d = csr_resp_data_i;
          err_d   = csr_resp_xcpt_i;
          state_d = S_RESP;
        end else if (timer_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_RESP: begin
        timer_d = '0;
        kill_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign core_req_ready_o  = core_rdy;
  assign dbg_req_ready_o   = dbg_rdy;

  assign csr_req_valid_o   = csr_vld;
  assign csr_req_cmd_o     = csr_vld ? cmd_q : CSR_CMD_NONE;
  assign csr_req_addr_o    = csr_vld ? addr_q : 12'h000;
  assign csr_req_data_o    = csr_vld ? wdata_q : 64'h0;

  assign core_resp_valid_o = (state_q == S_RESP) && (owner_q == OWN_CORE) && !kill_q && !flush_i;
  assign core_resp_data_o  = core_resp_valid_o ? rdata_q : 64'h0;
  assign core_resp_xcpt_o  = core_resp_valid_o ? err_q : 1'b0;

  assign dbg_resp_valid_o  = (state_q == S_RESP) && (owner_q == OWN_DBG);
  assign dbg_resp_data_o   = dbg_resp_valid_o ? rdata_q : 64'h0;
  assign dbg_resp_err_o    = dbg_resp_valid_o ? err_q : 1'b0;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Directed bench for csr_access_sequencer: core read, round-robin, debug
// gating, flush, timeout, exception pass-through and mid-access reset.
module tb_csr_access_sequencer;
  import csr_access_sequencer_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        core_req_valid_i = 1'b0;
  logic        core_req_ready_o;
  csr_cmd_t    core_req_cmd_i = CSR_CMD_NONE;
  logic [11:0] core_req_addr_i = '0;
  logic [63:0] core_req_data_i = '0;
  logic        core_resp_valid_o;
  logic [63:0] core_resp_data_o;
  logic        core_resp_xcpt_o;
  logic        flush_i = 1'b0;
  logic        dbg_req_valid_i = 1'b0;
  logic        dbg_req_ready_o;
  logic        dbg_req_write_i = 1'b0;
  logic [11:0] dbg_req_addr_i = '0;
  logic [63:0] dbg_req_data_i = '0;
  logic        dbg_resp_valid_o;
  logic [63:0] dbg_resp_data_o;
  logic        dbg_resp_err_o;
  logic        debug_mode_i = 1'b0;
  logic        csr_req_valid_o;
  csr_cmd_t    csr_req_cmd_o;
  logic [11:0] csr_req_addr_o;
  logic [63:0] csr_req_data_o;
  logic        csr_resp_valid_i = 1'b0;
  logic [63:0] csr_resp_data_i = '0;
  logic        csr_resp_xcpt_i = 1'b0;

  int vecs = 0;
  int errs = 0;

  always #5 clk_i = ~clk_i;

  csr_access_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
    .core_req_cmd_i(core_req_cmd_i), .core_req_addr_i(core_req_addr_i),
    .core_req_data_i(core_req_data_i),
    .core_resp_valid_o(core_resp_valid_o), .core_resp_data_o(core_resp_data_o),
    .core_resp_xcpt_o(core_resp_xcpt_o), .flush_i(flush_i),
    .dbg_req_valid_i(dbg_req_valid_i), .dbg_req_ready_o(dbg_req_ready_o),
    .dbg_req_write_i(dbg_req_write_i), .dbg_req_addr_i(dbg_req_addr_i),
    .dbg_req_data_i(dbg_req_data_i),
    .dbg_resp_valid_o(dbg_resp_valid_o), .dbg_resp_data_o(dbg_resp_data_o),
    .dbg_resp_err_o(dbg_resp_err_o), .debug_mode_i(debug_mode_i),
    .csr_req_valid_o(csr_req_valid_o), .csr_req_cmd_o(csr_req_cmd_o),
    .csr_req_addr_o(csr_req_addr_o), .csr_req_data_o(csr_req_data_o),
    .csr_resp_valid_i(csr_resp_valid_i), .csr_resp_data_i(csr_resp_data_i),
    .csr_resp_xcpt_i(csr_resp_xcpt_i)
  );

  // One clock: inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic core_issue(input csr_cmd_t cmd, input logic [11:0] addr);
    core_req_valid_i = 1'b1;
    core_req_cmd_i   = cmd;
    core_req_addr_i  = addr;
    core_req_data_i  = 64'h0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; core_req_valid_i = 1'b1; dbg_req_valid_i = 1'b1;
    debug_mode_i = 1'b1; csr_resp_valid_i = 1'b1;
    cyc(); cyc(); #1;
    vecs++; if (core_req_ready_o !== 1'b0) begin errs++; $display("FAIL rst_core_ready: got %0b want 0", core_req_ready_o); end
    vecs++; if (dbg_req_ready_o !== 1'b0) begin errs++; $display("FAIL rst_dbg_ready: got %0b want 0", dbg_req_ready_o); end
    vecs++; if (csr_req_valid_o !== 1'b0 || csr_req_addr_o !== 12'h0) begin errs++; $display("FAIL rst_csr_req: got v=%0b a=%h want 0", csr_req_valid_o, csr_req_addr_o); end
    vecs++; if (core_resp_valid_o !== 1'b0 || dbg_resp_valid_o !== 1'b0) begin errs++; $display("FAIL rst_resp: got core=%0b dbg=%0b want 0", core_resp_valid_o, dbg_resp_valid_o); end
    core_req_valid_i = 1'b0; dbg_req_valid_i = 1'b0; debug_mode_i = 1'b0;
    csr_resp_valid_i = 1'b0; rstn_i = 1'b1;
    cyc(); #1;
    vecs++; if (core_req_ready_o !== 1'b1) begin errs++; $display("FAIL post_rst_core_ready: got %0b want 1", core_req_ready_o); end
    vecs++; if (dbg_req_ready_o !== 1'b0) begin errs++; $display("FAIL post_rst_dbg_ready: got %0b want 0", dbg_req_ready_o); end
  endtask

  task automatic test_core_read();
    core_issue(CSR_CMD_READ, 12'h300); #1;
    vecs++; if (core_req_ready_o !== 1'b1) begin errs++; $display("FAIL rd_ready: got %0b want 1", core_req_ready_o); end
    cyc(); core_req_valid_i = 1'b0; #1;
    vecs++; if (csr_req_valid_o !== 1'b1 || csr_req_addr_o !== 12'h300 || csr_req_cmd_o !== CSR_CMD_READ) begin errs++; $display("FAIL rd_issue: got v=%0b a=%h c=%0d want 1 300 %0d", csr_req_valid_o, csr_req_addr_o, csr_req_cmd_o, CSR_CMD_READ); end
    cyc(); #1;
    vecs++; if (csr_req_valid_o !== 1'b0 || core_resp_valid_o !== 1'b0) begin errs++; $display("FAIL rd_wait: got req=%0b resp=%0b want 0 0", csr_req_valid_o, core_resp_valid_o); end
    cyc(); csr_resp_valid_i = 1'b1; csr_resp_data_i = 64'hA_0000_0000;
    cyc(); csr_resp_valid_i = 1'b0; csr_resp_data_i = 64'h0; #1;
    vecs++; if (core_resp_valid_o !== 1'b1 || core_resp_data_o !== 64'hA_0000_0000 || core_resp_xcpt_o !== 1'b0) begin errs++; $display("FAIL rd_resp: got v=%0b d=%h x=%0b want 1 a00000000 0", core_resp_valid_o, core_resp_data_o, core_resp_xcpt_o); end
    cyc(); #1;
    vecs++; if (core_resp_valid_o !== 1'b0 || core_req_ready_o !== 1'b1) begin errs++; $display("FAIL rd_after: got resp=%0b ready=%0b want 0 1", core_resp_valid_o, core_req_ready_o); end
  endtask

  task automatic test_round_robin();
    bit exp_core [4];
    exp_core = '{1'b1, 1'b0, 1'b1, 1'b0};
    rstn_i = 1'b0; cyc(); rstn_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      core_issue(CSR_CMD_READ, 12'h300);
      dbg_req_valid_i = 1'b1; dbg_req_write_i = 1'b0; dbg_req_addr_i = 12'h7B0;
      debug_mode_i = 1'b1; #1;
      vecs++; if (core_req_ready_o !== exp_core[i] || dbg_req_ready_o !== !exp_core[i]) begin errs++; $display("FAIL rr_grant%0d: got core=%0b dbg=%0b want core=%0b", i, core_req_ready_o, dbg_req_ready_o, exp_core[i]); end
      cyc(); core_req_valid_i = 1'b0; dbg_req_valid_i = 1'b0; #1;
      vecs++; if (csr_req_addr_o !== (exp_core[i] ? 12'h300 : 12'h7B0)) begin errs++; $display("FAIL rr_addr%0d: got %h want %h", i, csr_req_addr_o, exp_core[i] ? 12'h300 : 12'h7B0); end
      cyc(); csr_resp_valid_i = 1'b1; csr_resp_data_i = 64'(i + 16);
      cyc(); csr_resp_valid_i = 1'b0; #1;
      vecs++; if (core_resp_valid_o !== exp_core[i] || dbg_resp_valid_o !== !exp_core[i]) begin errs++; $display("FAIL rr_route%0d: got core=%0b dbg=%0b want core=%0b", i, core_resp_valid_o, dbg_resp_valid_o, exp_core[i]); end
      if (!exp_core[i]) begin
        vecs++; if (dbg_resp_data_o !== 64'(i + 16)) begin errs++; $display("FAIL rr_dbg_data%0d: got %h want %h", i, dbg_resp_data_o, 64'(i + 16)); end
      end
      cyc();
    end
  endtask

  task automatic test_debug_write();
    debug_mode_i = 1'b0;
    dbg_req_valid_i = 1'b1; dbg_req_write_i = 1'b1; dbg_req_addr_i = 12'h7B1;
    dbg_req_data_i = 64'h1234; #1;
    vecs++; if (dbg_req_ready_o !== 1'b0) begin errs++; $display("FAIL dbg_gated_ready: got %0b want 0", dbg_req_ready_o); end
    cyc(); #1;
    vecs++; if (csr_req_valid_o !== 1'b0) begin errs++; $display("FAIL dbg_gated_req: got %0b want 0", csr_req_valid_o); end
    debug_mode_i = 1'b1; #1;
    vecs++; if (dbg_req_ready_o !== 1'b1) begin errs++; $display("FAIL dbg_ready: got %0b want 1", dbg_req_ready_o); end
    cyc(); dbg_req_valid_i = 1'b0; #1;
    vecs++; if (csr_req_valid_o !== 1'b1 || csr_req_cmd_o !== CSR_CMD_WRITE || csr_req_addr_o !== 12'h7B1 || csr_req_data_o !== 64'h1234) begin errs++; $display("FAIL dbg_issue: got v=%0b c=%0d a=%h d=%h want 1 %0d 7b1 1234", csr_req_valid_o, csr_req_cmd_o, csr_req_addr_o, csr_req_data_o, CSR_CMD_WRITE); end
    cyc(); debug_mode_i = 1'b0; flush_i = 1'b1; csr_resp_valid_i = 1'b1; csr_resp_data_i = 64'h0;
    cyc(); csr_resp_valid_i = 1'b0; #1;
    vecs++; if (dbg_resp_valid_o !== 1'b1 || dbg_resp_err_o !== 1'b0 || core_resp_valid_o !== 1'b0) begin errs++; $display("FAIL dbg_resp: got v=%0b e=%0b core=%0b want 1 0 0", dbg_resp_valid_o, dbg_resp_err_o, core_resp_valid_o); end
    flush_i = 1'b0;
    cyc();
  endtask

  task automatic test_flush();
    core_issue(CSR_CMD_READ, 12'h301); flush_i = 1'b1; #1;
    vecs++; if (core_req_ready_o !== 1'b0) begin errs++; $display("FAIL fl_req_ready: got %0b want 0", core_req_ready_o); end
    cyc(); core_req_valid_i = 1'b0; flush_i = 1'b0; #1;
    vecs++; if (csr_req_valid_o !== 1'b0) begin errs++; $display("FAIL fl_req_noissue: got %0b want 0", csr_req_valid_o); end
    core_issue(CSR_CMD_READ, 12'h302);
    cyc(); core_req_valid_i = 1'b0; flush_i = 1'b1; #1;
    vecs++; if (csr_req_valid_o !== 1'b0 || csr_req_addr_o !== 12'h0) begin errs++; $display("FAIL fl_issue: got v=%0b a=%h want 0 000", csr_req_valid_o, csr_req_addr_o); end
    cyc(); flush_i = 1'b0; #1;
    vecs++; if (core_req_ready_o !== 1'b1) begin errs++; $display("FAIL fl_issue_idle: got ready=%0b want 1", core_req_ready_o); end
    cyc(); cyc(); #1;
    vecs++; if (core_resp_valid_o !== 1'b0 || csr_req_valid_o !== 1'b0) begin errs++; $display("FAIL fl_issue_quiet: got resp=%0b req=%0b want 0 0", core_resp_valid_o, csr_req_valid_o); end
    core_issue(CSR_CMD_WRITE, 12'h303);
    cyc(); core_req_valid_i = 1'b0; #1;
    vecs++; if (csr_req_valid_o !== 1'b1) begin errs++; $display("FAIL fl_wait_issue: got %0b want 1", csr_req_valid_o); end
    cyc(); flush_i = 1'b1;
    cyc(); flush_i = 1'b0; csr_resp_valid_i = 1'b1; csr_resp_data_i = 64'h77;
    cyc(); csr_resp_valid_i = 1'b0; #1;
    vecs++; if (core_resp_valid_o !== 1'b0) begin errs++; $display("FAIL fl_wait_resp: got %0b want 0", core_resp_valid_o); end
    cyc(); #1;
    vecs++; if (core_req_ready_o !== 1'b1 || core_resp_valid_o !== 1'b0) begin errs++; $display("FAIL fl_wait_idle: got ready=%0b resp=%0b want 1 0", core_req_ready_o, core_resp_valid_o); end
  endtask

  task automatic test_timeout();
    core_issue(CSR_CMD_READ, 12'h304);
    cyc(); core_req_valid_i = 1'b0;
    cyc();
    for (int k = 0; k < 8; k++) begin
      #1;
      vecs++; if (core_resp_valid_o !== 1'b0) begin errs++; $display("FAIL to_early%0d: got %0b want 0", k, core_resp_valid_o); end
      cyc();
    end
    #1;
    vecs++; if (core_resp_valid_o !== 1'b1 || core_resp_xcpt_o !== 1'b1 || core_resp_data_o !== 64'h0) begin errs++; $display("FAIL to_resp: got v=%0b x=%0b d=%h want 1 1 0", core_resp_valid_o, core_resp_xcpt_o, core_resp_data_o); end
    cyc(); csr_resp_valid_i = 1'b1; csr_resp_data_i = 64'hFF; #1;
    vecs++; if (core_resp_valid_o !== 1'b0 || csr_req_valid_o !== 1'b0) begin errs++; $display("FAIL to_late0: got resp=%0b req=%0b want 0 0", core_resp_valid_o, csr_req_valid_o); end
    cyc(); csr_resp_valid_i = 1'b0; #1;
    vecs++; if (core_resp_valid_o !== 1'b0 || dbg_resp_valid_o !== 1'b0 || core_req_ready_o !== 1'b1) begin errs++; $display("FAIL to_late1: got core=%0b dbg=%0b ready=%0b want 0 0 1", core_resp_valid_o, dbg_resp_valid_o, core_req_ready_o); end
  endtask

  task automatic test_xcpt_and_reset();
    core_issue(CSR_CMD_SYS, 12'h305);
    cyc(); core_req_valid_i = 1'b0;
    cyc(); csr_resp_valid_i = 1'b1; csr_resp_xcpt_i = 1'b1; csr_resp_data_i = 64'h5;
    cyc(); csr_resp_valid_i = 1'b0; csr_resp_xcpt_i = 1'b0; #1;
    vecs++; if (core_resp_valid_o !== 1'b1 || core_resp_xcpt_o !== 1'b1 || core_resp_data_o !== 64'h5) begin errs++; $display("FAIL xc_resp: got v=%0b x=%0b d=%h want 1 1 5", core_resp_valid_o, core_resp_xcpt_o, core_resp_data_o); end
    cyc();
    core_issue(CSR_CMD_READ, 12'h306);
    cyc(); core_req_valid_i = 1'b0;
    cyc(); rstn_i = 1'b0; csr_resp_valid_i = 1'b1; csr_resp_data_i = 64'h99; #1;
    vecs++; if (core_req_ready_o !== 1'b0 || dbg_req_ready_o !== 1'b0) begin errs++; $display("FAIL rs_ready: got core=%0b dbg=%0b want 0 0", core_req_ready_o, dbg_req_ready_o); end
    cyc(); rstn_i = 1'b1; csr_resp_valid_i = 1'b0; #1;
    vecs++; if (core_resp_valid_o !== 1'b0 || core_resp_data_o !== 64'h0 || csr_req_valid_o !== 1'b0 || dbg_resp_valid_o !== 1'b0) begin errs++; $display("FAIL rs_outputs: got resp=%0b d=%h req=%0b dbg=%0b want 0", core_resp_valid_o, core_resp_data_o, csr_req_valid_o, dbg_resp_valid_o); end
    vecs++; if (core_req_ready_o !== 1'b1) begin errs++; $display("FAIL rs_idle: got ready=%0b want 1", core_req_ready_o); end
    cyc(); #1;
    vecs++; if (core_resp_valid_o !== 1'b0) begin errs++; $display("FAIL rs_dropped: got %0b want 0", core_resp_valid_o); end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_round_robin();
    test_debug_write();
    test_flush();
    test_timeout();
    test_xcpt_and_reset();
    test_core_read();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
